// File: rtl/combat_ctrl.sv
// combat_ctrl: two-player round controller. It detects strike edges, queues one
// pending strike per player, services the strikes through a shared saturating
// subtractor with round-robin arbitration, and sequences the IDLE/FIGHT/KO round.
module combat_ctrl #(
  parameter int unsigned HP_INIT   = 250,
  parameter int unsigned HIT_DMG   = 10,
  parameter int unsigned BLOCK_DMG = 4,
  parameter int unsigned COOLDOWN  = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       hit_p1,
  input  logic       block_p1,
  input  logic       hit_p2,
  input  logic       block_p2,
  output logic [7:0] health1,
  output logic [7:0] health2,
  output logic       dmg_ack1,
  output logic       dmg_ack2,
  output logic       ko,
  output logic [1:0] winner,
  output logic [1:0] state
);

  localparam int unsigned CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [7:0]    HP    = 8'(HP_INIT);
  localparam logic [7:0]    HIT   = 8'(HIT_DMG);
  localparam logic [7:0]    BLK   = 8'(BLOCK_DMG);
  localparam logic [CW-1:0] COOL  = CW'(COOLDOWN);
  localparam logic [CW-1:0] CD_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FIGHT = 2'b01,
    KO    = 2'b10
  } state_t;

  state_t        cur, nxt;
  logic          prev1, prev2;
  logic          pend1, pend2;
  logic          type1, type2;     // 1 = unblocked hit
  logic [CW-1:0] cd1, cd2;
  logic          ptr;              // 1 = P2 wins the next contended cycle
  logic [7:0]    h1, h2;
  logic          ack1, ack2, ko_q;
  logic [1:0]    win_q;

  logic          act1, act2, accept1, accept2, svc1, svc2;
  logic          ko_hit, start_fight;
  logic [7:0]    sub_h, sub_d, sub_res;

  // Strike detection, arbitration, shared subtractor and next-state logic
  always_comb begin
    act1        = hit_p1 | block_p1;
    act2        = hit_p2 | block_p2;
    // A strike is accepted on the edge where the cooldown expires (count of 1).
    accept1     = (cur == FIGHT) && act1 && !prev1 && !pend1 && (cd1 == '0 || cd1 == CD_ONE);
    accept2     = (cur == FIGHT) && act2 && !prev2 && !pend2 && (cd2 == '0 || cd2 == CD_ONE);
    svc1        = (cur == FIGHT) && pend1 && (!pend2 || !ptr);
    svc2        = (cur == FIGHT) && pend2 && !svc1;
    sub_h       = svc1 ? h1 : h2;
    sub_d       = svc1 ? (type1 ? HIT : BLK) : (type2 ? HIT : BLK);
    sub_res     = (sub_h < sub_d) ? '0 : sub_h - sub_d;
    ko_hit      = (svc1 || svc2) && (sub_res == '0);
    start_fight = start && (cur == IDLE || cur == KO);
    nxt = cur;
    case (cur)
      IDLE:    if (start)  nxt = FIGHT;
      FIGHT:   if (ko_hit) nxt = KO;
      KO:      if (start)  nxt = FIGHT;
      default: nxt = IDLE;
    endcase
  end

  // Round state register
  always_ff @(posedge Clk) begin
    if (!Reset) cur <= IDLE;
    else        cur <= nxt;
  end

  // Health, pending strikes, cooldowns, arbitration pointer and result flags
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      prev1 <= 1'b0; prev2 <= 1'b0;
      pend1 <= 1'b0; pend2 <= 1'b0;
      type1 <= 1'b0; type2 <= 1'b0;
      cd1   <= '0;   cd2   <= '0;
      ptr   <= 1'b0;
      h1    <= HP;   h2    <= HP;
      ack1  <= 1'b0; ack2  <= 1'b0;
      ko_q  <= 1'b0; win_q <= '0;
    end else begin
      prev1 <= act1;
      prev2 <= act2;
      ack1  <= svc1;
      ack2  <= svc2;
      if (start_fight) begin
        h1    <= HP;   h2    <= HP;
        pend1 <= 1'b0; pend2 <= 1'b0;
        cd1   <= '0;   cd2   <= '0;
        ko_q  <= 1'b0; win_q <= '0;
      end else begin
        if (svc1)            cd1 <= COOL;
        else if (cd1 != '0)  cd1 <= cd1 - CD_ONE;
        if (svc2)            cd2 <= COOL;
        else if (cd2 != '0)  cd2 <= cd2 - CD_ONE;
        if (accept1) begin
          pend1 <= 1'b1;
          type1 <= hit_p1;
        end else if (svc1) begin
          pend1 <= 1'b0;
        end
        if (accept2) begin
          pend2 <= 1'b1;
          type2 <= hit_p2;
        end else if (svc2) begin
          pend2 <= 1'b0;
        end
        if (svc1) h1 <= sub_res;
        if (svc2) h2 <= sub_res;
        // The pointer only moves on contended cycles, so contention alternates.
        if (svc1 && pend2) ptr <= 1'b1;
        if (svc2 && pend1) ptr <= 1'b0;
        // A KO discards the opponent's pending strike, so a double KO cannot occur.
        if (ko_hit) begin
          pend1 <= 1'b0;
          pend2 <= 1'b0;
          ko_q  <= 1'b1;
          win_q <= svc1 ? 2'b10 : 2'b01;
        end
      end
    end
  end

  assign health1  = h1;
  assign health2  = h2;
  assign dmg_ack1 = ack1;
  assign dmg_ack2 = ack2;
  assign ko       = ko_q;
  assign winner   = win_q;
  assign state    = cur;

endmodule

// File: tb/tb_combat_ctrl.sv
// tb_combat_ctrl: directed self-checking bench for combat_ctrl.
module tb_combat_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, start, hit_p1, block_p1, hit_p2, block_p2;
  logic [7:0] health1, health2;
  logic       dmg_ack1, dmg_ack2, ko;
  logic [1:0] winner, state;

  int unsigned total = 0;
  int unsigned bad   = 0;

  combat_ctrl #(
    .HP_INIT   (250),
    .HIT_DMG   (10),
    .BLOCK_DMG (4),
    .COOLDOWN  (8)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .hit_p1   (hit_p1),
    .block_p1 (block_p1),
    .hit_p2   (hit_p2),
    .block_p2 (block_p2),
    .health1  (health1),
    .health2  (health2),
    .dmg_ack1 (dmg_ack1),
    .dmg_ack2 (dmg_ack2),
    .ko       (ko),
    .winner   (winner),
    .state    (state)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; start = 1'b0;
    hit_p1 = 1'b0; block_p1 = 1'b0; hit_p2 = 1'b0; block_p2 = 1'b0;
    tick(); tick();
    Reset = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One strike on player p (1 or 2), then enough idle cycles for cooldown to expire
  task automatic strike(input int p, input bit blk);
    if (p == 1) begin hit_p1 = !blk; block_p1 = blk; end
    else        begin hit_p2 = !blk; block_p2 = blk; end
    tick();
    hit_p1 = 1'b0; block_p1 = 1'b0; hit_p2 = 1'b0; block_p2 = 1'b0;
    tick();
    repeat (9) tick();
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_state", 16'(state), 16'd0);
    check("rst_h1", 16'(health1), 16'd250);
    check("rst_h2", 16'(health2), 16'd250);
    check("rst_ko", 16'(ko), 16'd0);
    check("rst_win", 16'(winner), 16'd0);
    check("rst_ack", 16'({dmg_ack1, dmg_ack2}), 16'd0);

    // Strikes in IDLE are ignored
    hit_p2 = 1'b1; tick(); hit_p2 = 1'b0; tick(); tick();
    check("idle_h2", 16'(health2), 16'd250);

    // Single hit on P2
    do_start();
    check("fight_state", 16'(state), 16'd1);
    hit_p2 = 1'b1; tick(); hit_p2 = 1'b0;
    check("s1_h2_detect", 16'(health2), 16'd250);
    tick();
    check("s1_h2", 16'(health2), 16'd240);
    check("s1_ack2", 16'(dmg_ack2), 16'd1);
    check("s1_h1", 16'(health1), 16'd250);
    tick();
    check("s1_ack2_off", 16'(dmg_ack2), 16'd0);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("s1_start_ign", 16'(health2), 16'd240);

    // Simultaneous hits: P1 first, then P2; next contention P2 first
    do_reset(); do_start();
    hit_p1 = 1'b1; hit_p2 = 1'b1; tick(); tick();
    check("s2_h1_first", 16'(health1), 16'd240);
    check("s2_h2_wait", 16'(health2), 16'd250);
    check("s2_ack1", 16'(dmg_ack1), 16'd1);
    tick();
    check("s2_h2_next", 16'(health2), 16'd240);
    check("s2_ack2", 16'(dmg_ack2), 16'd1);
    check("s2_ack1_off", 16'(dmg_ack1), 16'd0);
    tick(); tick();
    check("s2_held", 16'({health1, health2}), {8'd240, 8'd240});
    hit_p1 = 1'b0; hit_p2 = 1'b0;
    repeat (10) tick();
    hit_p1 = 1'b1; hit_p2 = 1'b1; tick(); tick();
    check("s2_rr_h2", 16'(health2), 16'd230);
    check("s2_rr_h1", 16'(health1), 16'd240);
    tick();
    check("s2_rr_h1b", 16'(health1), 16'd230);
    hit_p1 = 1'b0; hit_p2 = 1'b0;

    // Block, dropped block during cooldown, accepted block after cooldown
    do_reset(); do_start();
    block_p1 = 1'b1; tick(); tick();
    check("s3_blk1", 16'(health1), 16'd246);
    block_p1 = 1'b0; tick(); tick();
    block_p1 = 1'b1; tick(); tick(); tick();
    check("s3_dropped", 16'(health1), 16'd246);
    block_p1 = 1'b0;
    repeat (4) tick();
    block_p1 = 1'b1; tick(); tick();
    check("s3_blk2", 16'(health1), 16'd242);
    block_p1 = 1'b0;

    // Drive P2 to 6, then a saturating KO hit
    do_reset(); do_start();
    for (int i = 0; i < 24; i++) strike(2, 1'b0);
    strike(2, 1'b1);
    check("s4_h2_6", 16'(health2), 16'd6);
    hit_p2 = 1'b1; tick(); hit_p2 = 1'b0; tick();
    check("s4_h2_sat", 16'(health2), 16'd0);
    check("s4_state", 16'(state), 16'd2);
    check("s4_ko", 16'(ko), 16'd1);
    check("s4_win", 16'(winner), 16'd1);
    tick();
    hit_p1 = 1'b1; hit_p2 = 1'b1; tick(); tick();
    check("s4_ko_ack", 16'({dmg_ack1, dmg_ack2}), 16'd0);
    hit_p1 = 1'b0; hit_p2 = 1'b0; tick(); tick();
    check("s4_ko_h1", 16'(health1), 16'd250);
    check("s4_ko_h2", 16'(health2), 16'd0);

    // Restart from KO
    do_start();
    check("s5_state", 16'(state), 16'd1);
    check("s5_h", 16'({health1, health2}), {8'd250, 8'd250});
    check("s5_ko", 16'(ko), 16'd0);
    check("s5_win", 16'(winner), 16'd0);

    // Reset during P2 cooldown with P1 strike pending
    hit_p2 = 1'b1; tick(); hit_p2 = 1'b0; tick();
    check("s6_h2_pre", 16'(health2), 16'd240);
    tick();
    hit_p1 = 1'b1; tick(); hit_p1 = 1'b0;
    Reset = 1'b0; tick();
    check("s6_state", 16'(state), 16'd0);
    check("s6_h", 16'({health1, health2}), {8'd250, 8'd250});
    check("s6_ko_win", 16'({ko, winner}), 16'd0);
    check("s6_ack", 16'({dmg_ack1, dmg_ack2}), 16'd0);
    Reset = 1'b1; tick();
    check("s6_ack_after", 16'({dmg_ack1, dmg_ack2}), 16'd0);
    check("s6_h1_after", 16'(health1), 16'd250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/combat_ctrl.md
COMBAT_CTRL -- requirements
Module: combat_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- HP_INIT, 250, health loaded at reset and at round start.
- HIT_DMG, 10, damage for an unblocked strike.
- BLOCK_DMG, 4, damage for a blocked strike.
- COOLDOWN, 8, invulnerability cycles after damage is applied.

REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, input, 1, single clock; all logic on the rising edge.
- Reset, input, 1, synchronous active-low reset (0 = reset).
- start, input, 1, one-cycle round-start request.
- hit_p1, input, 1, level: P1 struck unblocked.
- block_p1, input, 1, level: P1 struck while blocking.
- hit_p2, input, 1, level: P2 struck unblocked.
- block_p2, input, 1, level: P2 struck while blocking.
- health1, output, 8, P1 health.
- health2, output, 8, P2 health.
- dmg_ack1, output, 1, one-cycle pulse: damage applied to P1.
- dmg_ack2, output, 1, one-cycle pulse: damage applied to P2.
- ko, output, 1, high while the round is over.
- winner, output, 2, 00 none, 01 P1 wins, 10 P2 wins.
- state, output, 2, 00 IDLE, 01 FIGHT, 10 KO.

Function
REQ-003 States and transitions:
- IDLE to FIGHT on start.
- FIGHT to KO when either health becomes 0.
- KO to FIGHT on start.
- No other transitions.
REQ-004 On entering FIGHT, health1 and health2 are reloaded to HP_INIT, and all pending flags and cooldowns are cleared.
REQ-005 Strike detection: per player, a registered previous sample of (hit|block); a strike is a 0->1 edge of (hit|block) sampled in FIGHT.
REQ-006 Strike on edge k sets the player's pending flag, records type (hit wins if hit and block are both high), only if that player's cooldown is 0 and pending is 0; otherwise the strike is dropped (no queue).
REQ-007 One shared subtractor: at most one player is serviced per cycle; a pending flag set at edge k is serviced at edge k+1 at the earliest.
REQ-008 Arbitration:
- If only one player is pending, that player is serviced.
- If both are pending, round-robin by last-serviced pointer; after reset the pointer gives P1 priority; the loser is serviced on the next edge.
REQ-009 Service:
- health = health - dmg, saturating at 0 (health < dmg gives 0); dmg is HIT_DMG or BLOCK_DMG per recorded type.
- Clear pending.
- Load cooldown = COOLDOWN.
- Pulse dmg_ackN high for exactly the cycle after the service edge.
REQ-010 Cooldown decrements by 1 per cycle to 0 and never wraps; a strike edge on the same edge cooldown reaches 0 is accepted.
REQ-011 KO entry:
- Service that yields health 0 moves state to KO on that same edge.
- ko = 1 and winner names the opponent from the next cycle.
- The other player's pending flag is discarded, so a double KO is impossible.
REQ-012 In IDLE and KO:
- Strikes are ignored.
- health1 and health2 hold their values.
- dmg_ack1 and dmg_ack2 stay 0.
REQ-013 Leaving KO:
- start clears ko and sets winner = 00 on the edge that enters FIGHT.
- start while in FIGHT is ignored.
REQ-014 Held-high hit or block inputs produce one strike only; a new strike requires (hit|block) to return to 0.

Reset
REQ-015 When Reset = 0 at a rising edge, the following values apply regardless of state, including mid-service or mid-cooldown:
- state = IDLE, health1 = health2 = HP_INIT.
- Pending flags, cooldowns and edge registers = 0.
- Round-robin pointer = P1.
- ko = 0, winner = 00, dmg_ack1 = dmg_ack2 = 0.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset, start, one hit_p2 rising edge -> health2 = 240 one edge after detection, dmg_ack2 = 1 for one cycle, health1 = 250.
- hit_p1 and hit_p2 rise on the same edge after reset -> P1 serviced first (health1 = 240), P2 serviced next edge (health2 = 240); repeat after cooldown -> P2 serviced first.
- block_p1 edge, then a second block_p1 edge 3 cycles later -> health1 = 246 only, second strike dropped; an edge 9+ cycles after service -> health1 = 242.
- Drive P2 health to 6, then hit_p2 -> health2 = 0 (saturated), state = KO, ko = 1, winner = 01; subsequent strikes leave health unchanged.
- In KO, pulse start -> state = FIGHT, both health = 250, ko = 0, winner = 00.
- Reset = 0 asserted during cooldown with a pending strike -> all outputs at REQ-015 values next cycle, no dmg_ack pulse.
